// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit: credit-limited requests to a variable-latency memory and an
// in-order DEPTH-entry response FIFO. Define IFU_DROP_COUNT_EN to add the drop_cnt output.
module if_prefetch_unit #(
    parameter int               PC_W     = 16,
    parameter int               INST_W   = 32,
    parameter int               DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc_plus1
`ifdef IFU_DROP_COUNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // Outstanding covers live requests plus stale ones still owed by memory after redirects.
    localparam int OUT_W = 8;

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [OUT_W-1:0] OUT_ONE = 1;

    logic [PC_W-1:0]   fetchPc;
    logic [PC_W-1:0]   respPc;
    logic [CNT_W-1:0]  count;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  discard;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;

    logic [INST_W-1:0] instMem [DEPTH];
    logic [PC_W-1:0]   pcMem   [DEPTH];

    logic [OUT_W-1:0]  live;
    logic [OUT_W:0]    inUse;
    logic              accept;
    logic              dropResp;
    logic              push;
    logic              pop;

    // NOTE: every signal gets a value on every path through always_comb, so no latch can form.
    always_comb begin
        live     = outstanding - discard;
        inUse    = {1'b0, live} + (OUT_W + 1)'(count);
        // Gating with rst holds the request low for the whole reset window, not just after an edge.
        mem_req  = rst && !redirect && (inUse < (OUT_W + 1)'(DEPTH));
        mem_addr = fetchPc;
        accept   = mem_req && mem_ready;
        dropResp = mem_rvalid && (redirect || (discard != '0));
        push     = mem_rvalid && !dropResp;
        pop      = inst_valid && !stall && !redirect;
    end

    always_comb begin
        inst_valid    = (count != '0);
        inst          = inst_valid ? instMem[rdPtr] : '0;
        inst_pc_plus1 = inst_valid ? pcMem[rdPtr]   : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else if (redirect) begin
            // Everything still owed by memory becomes stale; a response arriving now is dropped.
            fetchPc     <= redirect_pc;
            respPc      <= redirect_pc;
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            outstanding <= outstanding - OUT_W'(mem_rvalid);
            discard     <= outstanding - OUT_W'(mem_rvalid);
        end else begin
            if (accept) begin
                fetchPc <= fetchPc + PC_ONE;
            end
            if (push) begin
                respPc <= respPc + PC_ONE;
                wrPtr  <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (dropResp) begin
                discard <= discard - OUT_ONE;
            end
            outstanding <= outstanding + OUT_W'(accept) - OUT_W'(mem_rvalid);
            count       <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            instMem[wrPtr] <= mem_rdata;
            pcMem[wrPtr]   <= respPc + PC_ONE;
        end
    end

`ifdef IFU_DROP_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (dropResp && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomised scoreboard bench for if_prefetch_unit: a queue-based program-order model predicts
// the delivered instruction stream, request credit and (optionally) the discarded-response count.
module tb_if_prefetch_unit;

    localparam int          PC_W        = 16;
    localparam int          INST_W      = 32;
    localparam int          DEPTH       = 4;
    localparam logic [15:0] TB_RESET_PC = 16'hFFFE;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [INST_W-1:0] mem_rdata;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc_plus1;
`ifdef IFU_DROP_COUNT_EN
    logic [15:0]       drop_cnt;
`endif

    if_prefetch_unit #(
        .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(TB_RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc_plus1(inst_pc_plus1)
`ifdef IFU_DROP_COUNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
        int          epoch;
    } memReq_t;

    typedef struct {
        logic [31:0] word;
        logic [15:0] pcPlus1;
    } expItem_t;

    int          checks = 0;
    int          errors = 0;
    expItem_t    expQ[$];
    memReq_t     memPend[$];
    int          arrived = 0;
    int          epoch = 0;
    int          cycle = 0;
    int          dropModel = 0;
    logic [15:0] modelPc = TB_RESET_PC;
    int          readyPct = 100;
    int          latMin = 1;
    int          latMax = 1;

    function automatic logic [31:0] memWord(input logic [15:0] a);
        return {a ^ 16'hC3A5, a} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory: answers in request order, one response per cycle once the head is due.
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            mem_ready = rst && ($urandom_range(99) < readyPct);
            if (rst && (memPend.size() > 0) && (memPend[0].due <= cycle)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memWord(memPend[0].addr);
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
    end

    // Monitor: samples mid-cycle, compares against the model, then advances the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_mem_req", mem_req, 0);
                check("rst_mem_addr", mem_addr, TB_RESET_PC);
                check("rst_inst_valid", inst_valid, 0);
                check("rst_inst", inst, 0);
                check("rst_pc_plus1", inst_pc_plus1, 0);
                expQ.delete();
                memPend.delete();
                arrived   = 0;
                modelPc   = TB_RESET_PC;
                dropModel = 0;
                epoch++;
`ifdef IFU_DROP_COUNT_EN
                check("rst_drop_cnt", drop_cnt, 0);
`endif
            end else begin
                logic    expReq;
                logic    expValid;
                logic    rsp;
                logic    stale;
                memReq_t r;
                expItem_t h;

                expReq   = !redirect && (expQ.size() < DEPTH);
                expValid = (arrived > 0) && (expQ.size() > 0);
                check("mem_req", mem_req, expReq);
                check("mem_addr", mem_addr, modelPc);
                check("inst_valid", inst_valid, expValid);
                if (expValid) begin
                    h = expQ[0];
                    check("inst", inst, h.word);
                    check("inst_pc_plus1", inst_pc_plus1, h.pcPlus1);
                end else begin
                    check("inst_idle", inst, 0);
                    check("pc_plus1_idle", inst_pc_plus1, 0);
                end
`ifdef IFU_DROP_COUNT_EN
                check("drop_cnt", drop_cnt, dropModel);
`endif
                rsp   = mem_rvalid && (memPend.size() > 0);
                stale = 1'b0;
                if (rsp) begin
                    r     = memPend.pop_front();
                    stale = (r.epoch != epoch);
                end
                if (redirect) begin
                    if (rsp) dropModel++;
                    expQ.delete();
                    arrived = 0;
                    modelPc = redirect_pc;
                    epoch++;
                end else begin
                    if (rsp && stale) dropModel++;
                    if (expValid && !stall) begin
                        void'(expQ.pop_front());
                        arrived--;
                    end
                    if (rsp && !stale && (arrived < expQ.size())) arrived++;
                    if (mem_req && mem_ready) begin
                        expQ.push_back('{word: memWord(modelPc), pcPlus1: modelPc + 16'd1});
                        modelPc = modelPc + 16'd1;
                    end
                end
                if (mem_req && mem_ready) begin
                    memPend.push_back('{addr: mem_addr,
                                        due: cycle + $urandom_range(latMax, latMin),
                                        epoch: epoch});
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Streaming from RESET_PC across the 16-bit wrap.
        run(25);

        // Fill the FIFO under stall, then drain.
        stall = 1'b1;
        run(10);
        stall = 1'b0;
        run(10);

        // Three-cycle latency, redirect with requests in flight.
        latMin = 3;
        latMax = 3;
        run(12);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        run(1);
        redirect = 1'b0;
        run(15);

        // Redirect together with stall, then stall held.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        run(1);
        redirect = 1'b0;
        run(8);
        stall = 1'b0;
        run(10);

        // Back-to-back redirects.
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        run(1);
        redirect_pc = 16'h0300;
        run(1);
        redirect_pc = 16'hFFFD;
        run(1);
        redirect = 1'b0;
        run(15);

        // Random traffic.
        latMin   = 1;
        latMax   = 4;
        readyPct = 70;
        for (int i = 0; i < 600; i++) begin
            stall       = ($urandom_range(99) < 30);
            redirect    = ($urandom_range(99) < 5);
            redirect_pc = 16'($urandom);
            run(1);
        end
        stall    = 1'b0;
        redirect = 1'b0;
        readyPct = 100;
        latMin   = 2;
        latMax   = 2;
        run(10);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_mem_req", mem_req, 0);
        check("async_mem_addr", mem_addr, TB_RESET_PC);
        check("async_inst_valid", inst_valid, 0);
        check("async_inst", inst, 0);
        check("async_pc_plus1", inst_pc_plus1, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
